// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multi-cycle MIPS-subset CPU: sequences fetch/decode/execute/
// memory/writeback and drives datapath enables plus operand/PC mux selects.
module mc_ctrl_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_s;
  logic   illegal_s;

  function automatic logic is_legal_op(input logic [5:0] o);
    is_legal_op = (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) ||
                  (o == OP_BEQ)   || (o == OP_J)  || (o == OP_ADDI);
  endfunction

  // Moore control word for a state; handshake-qualified strobes are added separately.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RTYPEWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; op is only meaningful in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) state_d = S_MEMADR;
        else if (op == OP_RTYPE)            state_d = S_EXEC;
        else if (op == OP_BEQ)              state_d = S_BRANCH;
        else if (op == OP_J)                state_d = S_JUMP;
        else if (op == OP_ADDI)             state_d = S_ADDIEX;
        else                                state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_RTYPEWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register with the Moore control word pre-decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  // Ready-qualified fetch strobes and the reset gate that blocks all writes during rst.
  always_comb begin
    ctrl_s    = ctrl_q;
    illegal_s = 1'b0;
    if ((state_q == S_FETCH) && mem_ready) begin
      ctrl_s.ir_write = 1'b1;
      ctrl_s.pc_write = 1'b1;
    end else begin
      ctrl_s.ir_write = ctrl_q.ir_write;
    end
    if ((state_q == S_DECODE) && !is_legal_op(op)) illegal_s = 1'b1;
    else                                            illegal_s = 1'b0;
    if (rst) begin
      ctrl_s    = '0;
      illegal_s = 1'b0;
    end else begin
      illegal_s = illegal_s;
    end
  end

  assign pc_write      = ctrl_s.pc_write;
  assign pc_write_cond = ctrl_s.pc_write_cond;
  assign i_or_d        = ctrl_s.i_or_d;
  assign mem_read      = ctrl_s.mem_read;
  assign mem_write     = ctrl_s.mem_write;
  assign ir_write      = ctrl_s.ir_write;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign reg_dst       = ctrl_s.reg_dst;
  assign reg_write     = ctrl_s.reg_write;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign pc_source     = ctrl_s.pc_source;
  assign illegal_op    = illegal_s;
  assign state         = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Table-driven check of mc_ctrl_fsm: per-cycle state and control word, plus
// hand-written instruction-length sequences.
module tb_mc_ctrl_fsm;

  logic       clk, rst, mem_ready;
  logic [5:0] op;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pcw pcwc iod mr mw irw m2r rdst rw asa | asb(2) aop(2) psrc(2) | ill
  logic [16:0] act_ctl;
  assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op};

  localparam logic [16:0] E_ZERO     = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_FETCH    = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_FETCHR   = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_DECODE   = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_DEC_ILL  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [16:0] E_MEMADR   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MEMRD    = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MEMWB    = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_MEMWR    = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_EXEC     = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] E_RTWB     = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_BRANCH   = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [16:0] E_JUMP     = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] E_ADDIEX   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_ADDIWB   = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] o, input logic rdy,
                     input logic [3:0] st, input logic [16:0] ctl);
    vecs.push_back('{r, o, rdy, st, ctl});
  endtask

  // Runs one instruction from FETCH with ready tied high and checks its cycle count.
  task automatic run_len(input string name, input logic [5:0] o, input int exp_len);
    int cnt;
    op        = o;
    mem_ready = 1'b1;
    cnt       = 0;
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while ((state != 4'd0) && (cnt < 20));
    chk(name, cnt, exp_len);
  endtask

  initial begin
    rst = 1'b1; op = 6'h00; mem_ready = 1'b0;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) add(1'b1, 6'h00, 1'b0, 4'd0, E_ZERO);
    add(1'b0, 6'h00, 1'b0, 4'd0, E_FETCH);
    // LW, ready high
    add(1'b0, 6'h23, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h23, 1'b1, 4'd1, E_DECODE);
    add(1'b0, 6'h23, 1'b1, 4'd2, E_MEMADR);
    add(1'b0, 6'h23, 1'b1, 4'd3, E_MEMRD);
    add(1'b0, 6'h23, 1'b1, 4'd4, E_MEMWB);
    // SW with two wait cycles in MEMWR
    add(1'b0, 6'h2B, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h2B, 1'b1, 4'd1, E_DECODE);
    add(1'b0, 6'h2B, 1'b1, 4'd2, E_MEMADR);
    add(1'b0, 6'h2B, 1'b0, 4'd5, E_MEMWR);
    add(1'b0, 6'h2B, 1'b0, 4'd5, E_MEMWR);
    add(1'b0, 6'h2B, 1'b1, 4'd5, E_MEMWR);
    // R-type, BEQ, J, ADDI back to back
    add(1'b0, 6'h00, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h00, 1'b1, 4'd1, E_DECODE);
    add(1'b0, 6'h00, 1'b1, 4'd6, E_EXEC);
    add(1'b0, 6'h00, 1'b1, 4'd7, E_RTWB);
    add(1'b0, 6'h04, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h04, 1'b1, 4'd1, E_DECODE);
    add(1'b0, 6'h04, 1'b1, 4'd8, E_BRANCH);
    add(1'b0, 6'h02, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h02, 1'b1, 4'd1, E_DECODE);
    add(1'b0, 6'h02, 1'b1, 4'd9, E_JUMP);
    add(1'b0, 6'h08, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h08, 1'b1, 4'd1, E_DECODE);
    add(1'b0, 6'h08, 1'b1, 4'd10, E_ADDIEX);
    add(1'b0, 6'h08, 1'b1, 4'd11, E_ADDIWB);
    // FETCH stall for four cycles, then an illegal opcode
    for (int i = 0; i < 4; i++) add(1'b0, 6'h3F, 1'b0, 4'd0, E_FETCH);
    add(1'b0, 6'h3F, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h3F, 1'b0, 4'd1, E_DEC_ILL);
    add(1'b0, 6'h3F, 1'b0, 4'd0, E_FETCH);
    // reset asserted while MEMRD is waiting on memory
    add(1'b0, 6'h23, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h23, 1'b1, 4'd1, E_DECODE);
    add(1'b0, 6'h23, 1'b1, 4'd2, E_MEMADR);
    add(1'b0, 6'h23, 1'b0, 4'd3, E_MEMRD);
    add(1'b1, 6'h23, 1'b1, 4'd3, E_ZERO);
    add(1'b0, 6'h23, 1'b0, 4'd0, E_FETCH);
    add(1'b0, 6'h23, 1'b1, 4'd0, E_FETCHR);
    add(1'b0, 6'h00, 1'b1, 4'd1, E_DECODE);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      op        = vecs[i].op;
      mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_ctl", i), act_ctl, vecs[i].ctl);
      chk($sformatf("vec%0d_rd_wr_excl", i), mem_read & mem_write, 1'b0);
      chk($sformatf("vec%0d_rw_pcw_excl", i), reg_write & pc_write, 1'b0);
    end

    // drain the R-type left in flight, bounded
    begin
      int guard;
      guard = 0;
      mem_ready = 1'b1;
      do begin
        @(negedge clk);
        #1;
        guard++;
      end while ((state != 4'd0) && (guard < 20));
      chk("drain_to_fetch", state, 4'd0);
    end

    run_len("len_lw",   6'h23, 5);
    run_len("len_sw",   6'h2B, 4);
    run_len("len_rtype",6'h00, 4);
    run_len("len_addi", 6'h08, 4);
    run_len("len_beq",  6'h04, 3);
    run_len("len_j",    6'h02, 3);
    run_len("len_ill",  6'h3F, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
